keypad4x4_scan: RTL

- Input-side counterpart of the multiplexed 4-digit 7-segment driver.
- Scans a 4x4 key matrix one column at a time and synchronises and debounces the row returns.
- Emits a 4-bit key code with a one-cycle valid strobe and a held-key level.
- Sits beside the display path on the board top. Its key code can feed the display drivers directly.

---
 rtl/keypad4x4_scan.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/keypad4x4_scan.sv
// 4x4 key matrix scanner: walks an active-low column strobe, synchronises the
// row returns, debounces one captured key and reports its code, a strobe and a hold level.
module keypad4x4_scan #(
    parameter logic [25:0] SCAN_MAX = 26'd99999,
    parameter int          DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       valid,
    output logic       pressed
);

    localparam logic [3:0] DEB_TGT = 4'(DEB_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t      r_state, w_state_nx;
    logic [25:0] r_presc;
    logic [3:0]  r_rs1, r_rs;
    logic [1:0]  r_col_idx, w_col_nx;
    logic [1:0]  r_row_idx, w_row_nx;
    logic [3:0]  r_deb, w_deb_nx;
    logic [3:0]  r_key, w_key_nx;
    logic [3:0]  r_col;
    logic        r_valid, w_valid_nx;
    logic        r_pressed, w_pressed_nx;
    logic        w_tick;
    logic        w_rsel;
    logic [1:0]  w_low;
    logic [3:0]  w_deb_inc;
    logic [1:0]  w_col_inc;

    assign w_tick    = (r_presc == SCAN_MAX);
    assign w_rsel    = r_rs[r_row_idx];
    assign w_deb_inc = r_deb + 4'd1;
    assign w_col_inc = r_col_idx + 2'd1;

    // Lowest-numbered active row wins when several rows are pulled low.
    always_comb begin
        w_low = 2'd3;
        if (!r_rs[0])      w_low = 2'd0;
        else if (!r_rs[1]) w_low = 2'd1;
        else if (!r_rs[2]) w_low = 2'd2;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_col_nx     = r_col_idx;
        w_row_nx     = r_row_idx;
        w_deb_nx     = r_deb;
        w_key_nx     = r_key;
        w_valid_nx   = 1'b0;
        w_pressed_nx = r_pressed;
        case (r_state)
            SCAN: begin
                if (w_tick) begin
                    if (r_rs != 4'b1111) begin
                        w_row_nx   = w_low;
                        w_deb_nx   = 4'd0;
                        w_state_nx = DEBOUNCE;
                    end else begin
                        w_col_nx = w_col_inc;
                    end
                end
            end
            DEBOUNCE: begin
                if (w_tick) begin
                    if (!w_rsel) begin
                        w_deb_nx = w_deb_inc;
                        if (w_deb_inc == DEB_TGT) begin
                            w_key_nx     = {r_row_idx, r_col_idx};
                            w_valid_nx   = 1'b1;
                            w_pressed_nx = 1'b1;
                            w_state_nx   = HELD;
                        end
                    end else begin
                        w_col_nx   = w_col_inc;
                        w_state_nx = SCAN;
                    end
                end
            end
            HELD: begin
                w_pressed_nx = 1'b1;
                if (w_tick && w_rsel) begin
                    w_deb_nx   = 4'd0;
                    w_state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (w_tick) begin
                    if (w_rsel) begin
                        w_deb_nx = w_deb_inc;
                        if (w_deb_inc == DEB_TGT) begin
                            w_col_nx     = w_col_inc;
                            w_pressed_nx = 1'b0;
                            w_state_nx   = SCAN;
                        end
                    end else begin
                        w_deb_nx   = 4'd0;
                        w_state_nx = HELD;
                    end
                end
            end
            default: w_state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= SCAN;
            r_presc   <= 26'd0;
            r_rs1     <= 4'b1111;
            r_rs      <= 4'b1111;
            r_col_idx <= 2'd0;
            r_row_idx <= 2'd0;
            r_deb     <= 4'd0;
            r_key     <= 4'h0;
            r_col     <= 4'b1110;
            r_valid   <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_presc   <= w_tick ? 26'd0 : r_presc + 26'd1;
            r_rs1     <= row;
            r_rs      <= r_rs1;
            r_col_idx <= w_col_nx;
            r_row_idx <= w_row_nx;
            r_deb     <= w_deb_nx;
            r_key     <= w_key_nx;
            // Column drive is registered from the next index so it tracks r_col_idx exactly.
            r_col     <= ~(4'b0001 << w_col_nx);
            r_valid   <= w_valid_nx;
            r_pressed <= w_pressed_nx;
        end
    end

    assign col     = r_col;
    assign key     = r_key;
    assign valid   = r_valid;
    assign pressed = r_pressed;

endmodule
